// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO: frames are start, LSB-first data, optional parity, stop bit(s).
// txd falls two edges after a write into an empty idle block; writes arriving while full are dropped.
module uart_tx_fifo #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 10417,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data,
    input  logic              transmit,
    output logic              txd,
    output logic              busy,
    output logic              full,
    output logic              empty
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int IDX_W  = $clog2(DATA_W);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  DATA_LAST = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0]  STOP_LAST = IDX_W'(STOP_BITS - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic              ODD_PAR   = (PARITY == 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              par_q, par_d;
    logic              txd_q, txd_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              push, pop, bit_end;
    logic [DATA_W-1:0] head;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == FULL_CNT);
    assign busy    = (state_q != S_IDLE);
    assign txd     = txd_q;
    assign push    = transmit && !full;
    assign head    = mem_q[rd_ptr_q];
    assign bit_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = bit_end ? '0 : baud_q + BAUD_W'(1);
        idx_d   = idx_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                idx_d  = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shreg_d = shreg_q >> 1;
                    if (idx_q == DATA_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_PAR: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    idx_d   = '0;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (idx_q == STOP_LAST) begin
                        idx_d = '0;
                        // Chain straight into the next start bit when more words wait.
                        if (!empty) begin
                            pop     = 1'b1;
                            state_d = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (pop) begin
            shreg_d = head;
            par_d   = (^head) ^ ODD_PAR;
        end
    end

    // Line level follows the current state, so txd lags the FSM by one cycle.
    always_comb begin
        case (state_q)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = shreg_q[0];
            S_PAR:   txd_d = par_q;
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            idx_q    <= '0;
            shreg_q  <= '0;
            par_q    <= 1'b0;
            txd_q    <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) mem_q[wr_ptr_q] <= data;
    end

endmodule
